alu_flag_unit: RTL and testbench



---
 rtl/alu_flag_unit_pkg.sv | 51 +++++
 rtl/alu_flag_unit_zero_chunk_reduce.sv | 24 ++
 rtl/alu_flag_unit.sv | 128 ++++++++++++
 tb/tb_alu_flag_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_flag_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_unit_pkg
// Brief    : Branch-condition encodings, flag bit indices and condition decode
// Revision : 1.0 - initial release
// ============================================================================
package alu_flag_unit_pkg;

    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_ALWAYS = 3'b001;
    localparam logic [2:0] COND_EQ     = 3'b010;
    localparam logic [2:0] COND_NE     = 3'b011;
    localparam logic [2:0] COND_LT     = 3'b100;
    localparam logic [2:0] COND_GE     = 3'b101;
    localparam logic [2:0] COND_CS     = 3'b110;
    localparam logic [2:0] COND_CC     = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int NFLAGS = 4;

    typedef logic [NFLAGS-1:0] flags_t;

    // Only "always" may fire before any flag update has completed.
    function automatic logic cond_eval(
        input flags_t     f,
        input logic [2:0] sel,
        input logic       valid
    );
        logic taken;
        case (sel)
            COND_NEVER:  taken = 1'b0;
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = f[FLAG_Z];
            COND_NE:     taken = ~f[FLAG_Z];
            COND_LT:     taken = f[FLAG_N] ^ f[FLAG_V];
            COND_GE:     taken = ~(f[FLAG_N] ^ f[FLAG_V]);
            COND_CS:     taken = f[FLAG_C];
            COND_CC:     taken = ~f[FLAG_C];
            default:     taken = 1'b0;
        endcase
        if (!valid && (sel != COND_ALWAYS)) begin
            taken = 1'b0;
        end
        return taken;
    endfunction

endpackage : alu_flag_unit_pkg
`default_nettype wire

// File: rtl/alu_flag_unit_zero_chunk_reduce.sv
`default_nettype none
// ============================================================================
// Module   : zero_chunk_reduce
// Brief    : Per-chunk zero detect of a WIDTH-bit word; top chunk may be short
// Revision : 1.0 - initial release
// ============================================================================
module zero_chunk_reduce #(
    parameter int WIDTH  = 8,
    parameter int CHUNK  = 8,
    parameter int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK
) (
    input  logic [WIDTH-1:0]  data_i,
    output logic [NCHUNK-1:0] pz_o
);

    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
        // Bits beyond WIDTH do not exist, so the top chunk is simply narrower.
        localparam int LO = i * CHUNK;
        localparam int HI = ((LO + CHUNK) > WIDTH) ? (WIDTH - 1) : (LO + CHUNK - 1);
        assign pz_o[i] = ~|data_i[HI:LO];
    end

endmodule : zero_chunk_reduce
`default_nettype wire

// File: rtl/alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_unit
// Brief    : Registered Z/N/C/V flag capture with optional zero-reduce stage
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 8,
    parameter int PIPE  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             res_valid,
    input  logic             flag_we,
    input  logic             flag_clr,
    input  logic [2:0]       cond_sel,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             flags_valid,
    output logic             branch_taken
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

    logic [NCHUNK-1:0] w_pz;
    logic              w_upd;
    logic              w_ld;
    logic              w_ld_zero;
    logic              w_ld_msb;
    logic              w_ld_carry;
    logic              w_ld_ovf;

    flags_t            flags_q;
    flags_t            flags_d;
    logic              valid_q;
    logic              valid_d;

    assign w_upd = res_valid & flag_we;

    zero_chunk_reduce #(
        .WIDTH  (WIDTH),
        .CHUNK  (CHUNK),
        .NCHUNK (NCHUNK)
    ) u_zero_reduce (
        .data_i (result),
        .pz_o   (w_pz)
    );

    if (PIPE != 0) begin : g_pipe
        logic [NCHUNK-1:0] s1_pz_q;
        logic              s1_msb_q;
        logic              s1_carry_q;
        logic              s1_ovf_q;
        logic              s1_upd_q;

        // S1 captures every cycle; a clear only wins at the flag register,
        // so an update issued with the clear still lands one cycle later.
        always_ff @(posedge CLK) begin
            if (!RESET) begin
                s1_pz_q    <= '0;
                s1_msb_q   <= 1'b0;
                s1_carry_q <= 1'b0;
                s1_ovf_q   <= 1'b0;
                s1_upd_q   <= 1'b0;
            end else begin
                s1_pz_q    <= w_pz;
                s1_msb_q   <= result[WIDTH-1];
                s1_carry_q <= carry_in;
                s1_ovf_q   <= ovf_in;
                s1_upd_q   <= w_upd;
            end
        end

        assign w_ld       = s1_upd_q;
        assign w_ld_zero  = &s1_pz_q;
        assign w_ld_msb   = s1_msb_q;
        assign w_ld_carry = s1_carry_q;
        assign w_ld_ovf   = s1_ovf_q;
    end else begin : g_nopipe
        assign w_ld       = w_upd;
        assign w_ld_zero  = &w_pz;
        assign w_ld_msb   = result[WIDTH-1];
        assign w_ld_carry = carry_in;
        assign w_ld_ovf   = ovf_in;
    end

    always_comb begin
        flags_d = flags_q;
        valid_d = valid_q;
        if (flag_clr) begin
            flags_d = '0;
            valid_d = 1'b0;
        end else if (w_ld) begin
            flags_d[FLAG_Z] = w_ld_zero;
            flags_d[FLAG_N] = w_ld_msb;
            flags_d[FLAG_C] = w_ld_carry;
            flags_d[FLAG_V] = w_ld_ovf;
            valid_d         = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign zero         = flags_q[FLAG_Z];
    assign neg          = flags_q[FLAG_N];
    assign carry        = flags_q[FLAG_C];
    assign ovf          = flags_q[FLAG_V];
    assign flags_valid  = valid_q;
    assign branch_taken = cond_eval(flags_q, cond_sel, valid_q);

endmodule : alu_flag_unit
`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_flag_unit
// Brief    : Directed self-checking bench over three parameter sets
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        carry_in, ovf_in, res_valid, flag_we, flag_clr;
    logic [2:0]  cond_sel;
    logic [11:0] res_a;
    logic [7:0]  res_b;
    logic [31:0] res_c;

    logic a_z, a_n, a_c, a_v, a_fv, a_bt;
    logic b_z, b_n, b_c, b_v, b_fv, b_bt;
    logic c_z, c_n, c_c, c_v, c_fv, c_bt;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    alu_flag_unit #(.WIDTH(12), .CHUNK(8), .PIPE(1)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .result(res_a), .carry_in(carry_in), .ovf_in(ovf_in),
        .res_valid(res_valid), .flag_we(flag_we), .flag_clr(flag_clr), .cond_sel(cond_sel),
        .zero(a_z), .neg(a_n), .carry(a_c), .ovf(a_v), .flags_valid(a_fv), .branch_taken(a_bt)
    );

    alu_flag_unit #(.WIDTH(8), .CHUNK(8), .PIPE(1)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .result(res_b), .carry_in(carry_in), .ovf_in(ovf_in),
        .res_valid(res_valid), .flag_we(flag_we), .flag_clr(flag_clr), .cond_sel(cond_sel),
        .zero(b_z), .neg(b_n), .carry(b_c), .ovf(b_v), .flags_valid(b_fv), .branch_taken(b_bt)
    );

    alu_flag_unit #(.WIDTH(32), .CHUNK(8), .PIPE(0)) u_dut_c (
        .CLK(CLK), .RESET(RESET), .result(res_c), .carry_in(carry_in), .ovf_in(ovf_in),
        .res_valid(res_valid), .flag_we(flag_we), .flag_clr(flag_clr), .cond_sel(cond_sel),
        .zero(c_z), .neg(c_n), .carry(c_c), .ovf(c_v), .flags_valid(c_fv), .branch_taken(c_bt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        flag_we   = 1'b1;
        flag_clr  = 1'b0;
    endtask

    logic [7:0] exp_bt;

    initial begin
        RESET = 1'b0; res_valid = 1'b1; flag_we = 1'b1; flag_clr = 1'b0;
        carry_in = 1'b0; ovf_in = 1'b0; cond_sel = 3'b010;
        res_a = '0; res_b = '0; res_c = '0;
        #1;

        // Reset held for two edges while updates are presented
        tick(); tick();
        check("rst_a_zero", a_z, 0);
        check("rst_a_fv",   a_fv, 0);
        check("rst_a_bt",   a_bt, 0);
        check("rst_c_zero", c_z, 0);
        check("rst_c_fv",   c_fv, 0);
        check("rst_c_bt",   c_bt, 0);

        RESET = 1'b1;
        tick();
        check("rel_c_zero_1cyc", c_z, 1);
        check("rel_a_zero_1cyc", a_z, 0);
        tick();
        check("rel_a_zero_2cyc", a_z, 1);
        check("rel_a_fv",        a_fv, 1);
        check("rel_a_bt_eq",     a_bt, 1);
        idle();
        tick(); tick();

        // Zero detect across a short top chunk (W=12, CHUNK=8)
        res_a = 12'h800; res_valid = 1'b1; tick(); idle(); tick();
        check("a_800_zero", a_z, 0);
        check("a_800_neg",  a_n, 1);
        res_a = 12'h001; res_valid = 1'b1; tick(); idle(); tick();
        check("a_001_zero", a_z, 0);
        check("a_001_neg",  a_n, 0);
        res_a = 12'h000; res_valid = 1'b1; tick(); idle(); tick();
        check("a_000_zero", a_z, 1);

        // Back-to-back pipelined updates on W=8
        res_b = 8'h00; res_valid = 1'b1; tick();
        res_b = 8'h05; tick();
        check("b2b_0_zero", b_z, 1);
        check("b2b_0_neg",  b_n, 0);
        res_b = 8'h80; tick();
        check("b2b_1_zero", b_z, 0);
        check("b2b_1_neg",  b_n, 0);
        res_b = 8'h00; flag_we = 1'b0; tick();
        check("b2b_2_zero", b_z, 0);
        check("b2b_2_neg",  b_n, 1);
        idle(); tick();
        check("nowe_zero", b_z, 0);
        check("nowe_neg",  b_n, 1);
        tick();
        check("hold_neg", b_n, 1);

        // Clear colliding with a Z=1 load; update issued with the clear lands next
        res_b = 8'h00; res_valid = 1'b1; tick();
        res_b = 8'h80; flag_clr = 1'b1; tick();
        check("clr_zero", b_z, 0);
        check("clr_neg",  b_n, 0);
        check("clr_fv",   b_fv, 0);
        cond_sel = 3'b001;
        #1 check("clr_bt_always", b_bt, 1);
        cond_sel = 3'b111;
        #1 check("clr_bt_cc_forced", b_bt, 0);
        idle(); tick();
        check("clr_upd_neg", b_n, 1);
        check("clr_upd_fv",  b_fv, 1);

        // Branch sweep with N=1 V=0 C=1 Z=0
        res_b = 8'h80; carry_in = 1'b1; ovf_in = 1'b0; res_valid = 1'b1;
        tick(); idle(); tick();
        check("br_carry", b_c, 1);
        check("br_ovf",   b_v, 0);
        exp_bt = 8'b0101_1010;
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1 check($sformatf("br_sel%0d", s), b_bt, exp_bt[s]);
        end

        // N=1 V=1 makes LT false, GE true
        ovf_in = 1'b1; res_valid = 1'b1; tick(); idle(); tick();
        check("v_ovf", b_v, 1);
        cond_sel = 3'b100;
        #1 check("v_lt", b_bt, 0);
        cond_sel = 3'b101;
        #1 check("v_ge", b_bt, 1);
        carry_in = 1'b0; ovf_in = 1'b0;

        // PIPE=0 single-cycle latency on W=32
        res_c = 32'h0001_0000; res_valid = 1'b1; tick();
        check("c_10000_zero", c_z, 0);
        res_c = 32'h0000_0000; tick();
        check("c_0_zero", c_z, 1);
        res_c = 32'h8000_0000; tick();
        check("c_msb_zero", c_z, 0);
        check("c_msb_neg",  c_n, 1);
        idle(); res_c = 32'h0; tick();
        check("c_hold_zero", c_z, 0);

        // Reset mid-flight discards an S1 entry
        res_b = 8'h00; res_valid = 1'b1; tick();
        idle(); RESET = 1'b0; tick();
        RESET = 1'b1; tick();
        check("rst_mid_zero", b_z, 0);
        check("rst_mid_fv",   b_fv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_flag_unit
`default_nettype wire
